// File: rtl/instr_fetch.sv
// Instruction fetch unit: fetch PC, single-outstanding imem read handshake, 2-entry
// instruction FIFO, branch redirect and sticky halt. Optional macro FETCH_BYPASS_EN.
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  output logic [31:0] instruction,
  output logic [31:0] instr_pc,
  input  logic        instr_ready,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        ill_instr,
  output logic        halted,
  output logic        fetch_err
);

  typedef enum logic [1:0] {ST_RUN, ST_WAIT, ST_HALT} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] req_pc_q, req_pc_d;
  logic        req_q, req_d;
  logic        discard_q, discard_d;
  logic        halted_q, halted_d;
  logic        err_q, err_d;
  logic        v0_q, v0_d, v1_q, v1_d;
  logic [31:0] i0_q, i0_d, p0_q, p0_d;
  logic [31:0] i1_q, i1_d, p1_q, p1_d;

  logic        accept;
  logic        push;
  logic        bypass;
  logic        out_valid;

`ifdef FETCH_BYPASS_EN
  // An accepted, non-discarded response goes straight to decode when the FIFO is empty.
  assign bypass      = (state_q == ST_WAIT) && imem_rvalid && !discard_q && !v0_q && !redirect;
  assign out_valid   = v0_q | bypass;
  assign instruction = v0_q ? i0_q : imem_rdata;
  assign instr_pc    = v0_q ? p0_q : req_pc_q;
`else
  assign bypass      = 1'b0;
  assign out_valid   = v0_q;
  assign instruction = i0_q;
  assign instr_pc    = p0_q;
`endif

  assign instr_valid = out_valid;
  assign imem_req    = req_q;
  assign imem_addr   = pc_q;
  assign halted      = halted_q;
  assign fetch_err   = err_q;
  assign accept      = (state_q == ST_RUN) && req_q && imem_ready;

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    req_pc_d  = req_pc_q;
    discard_d = discard_q;
    halted_d  = halted_q;
    err_d     = err_q;
    v0_d      = v0_q;
    v1_d      = v1_q;
    i0_d      = i0_q;
    p0_d      = p0_q;
    i1_d      = i1_q;
    p1_d      = p1_q;
    push      = 1'b0;

    if (state_q == ST_HALT) begin
      state_d = ST_HALT;
    end else if (out_valid && ill_instr) begin
      state_d  = ST_HALT;
      halted_d = 1'b1;
      v0_d     = 1'b0;
      v1_d     = 1'b0;
    end else if (redirect) begin
      v0_d = 1'b0;
      v1_d = 1'b0;
      if (redirect_pc[1:0] != 2'b00) begin
        state_d  = ST_HALT;
        halted_d = 1'b1;
        err_d    = 1'b1;
      end else begin
        pc_d = redirect_pc;
        // The in-flight read (old or just accepted) belongs to the wrong path.
        if (state_q == ST_WAIT) begin
          if (imem_rvalid) begin
            state_d   = ST_RUN;
            discard_d = 1'b0;
          end else begin
            discard_d = 1'b1;
          end
        end else if (accept) begin
          state_d   = ST_WAIT;
          discard_d = 1'b1;
          req_pc_d  = pc_q;
        end
      end
    end else begin
      if (accept) begin
        pc_d     = pc_q + 32'd4;
        req_pc_d = pc_q;
        state_d  = ST_WAIT;
      end
      if ((state_q == ST_WAIT) && imem_rvalid) begin
        state_d   = ST_RUN;
        discard_d = 1'b0;
        push      = !discard_q && !(bypass && instr_ready);
      end
      if (v0_q && instr_ready) begin
        v0_d = v1_q;
        i0_d = i1_q;
        p0_d = p1_q;
        v1_d = 1'b0;
      end
      if (push) begin
        if (!v0_d) begin
          v0_d = 1'b1;
          i0_d = imem_rdata;
          p0_d = req_pc_q;
        end else begin
          v1_d = 1'b1;
          i1_d = imem_rdata;
          p1_d = req_pc_q;
        end
      end
    end

    // Request issue looks only at the settled state/occupancy of the next cycle.
    req_d = (state_d == ST_RUN) && !(v0_d && v1_d);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_RUN;
      pc_q      <= RESET_PC;
      req_pc_q  <= 32'd0;
      req_q     <= 1'b0;
      discard_q <= 1'b0;
      halted_q  <= 1'b0;
      err_q     <= 1'b0;
      v0_q      <= 1'b0;
      v1_q      <= 1'b0;
      i0_q      <= 32'd0;
      p0_q      <= 32'd0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      req_pc_q  <= req_pc_d;
      req_q     <= req_d;
      discard_q <= discard_d;
      halted_q  <= halted_d;
      err_q     <= err_d;
      v0_q      <= v0_d;
      v1_q      <= v1_d;
      i0_q      <= i0_d;
      p0_q      <= p0_d;
    end
  end

  always_ff @(posedge clk) begin
    i1_q <= i1_d;
    p1_q <= p1_d;
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: memory responder, queue-based reference model checked
// every cycle, and literal expectations for each scenario.
module tb_instr_fetch;

  localparam logic [31:0] RPC = 32'h0000_0100;

  logic        clk;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic [31:0] instruction;
  logic [31:0] instr_pc;
  logic        instr_ready;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        ill_instr;
  logic        halted;
  logic        fetch_err;

  instr_fetch #(.RESET_PC(RPC)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .instr_valid(instr_valid), .instruction(instruction), .instr_pc(instr_pc),
    .instr_ready(instr_ready), .redirect(redirect), .redirect_pc(redirect_pc),
    .ill_instr(ill_instr), .halted(halted), .fetch_err(fetch_err)
  );

  typedef struct packed {
    logic [31:0] ins;
    logic [31:0] pc;
  } ent_t;

  int errors = 0;
  int checks = 0;
  int lat = 1;

  // reference model state
  ent_t        q[$];
  logic        m_halt, m_err, m_wait, m_disc, m_started;
  logic [31:0] m_addr, m_rpc;

  logic [31:0] acc_log[$];
  ent_t        pop_log[$];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0000_0100: mem_word = 32'h0050_0093;
      32'h0000_0104: mem_word = 32'h00A0_0113;
      32'h0000_0300: mem_word = 32'hFFFF_FFFF;
      default:       mem_word = a ^ 32'h1357_0000;
    endcase
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] acc_at(input int i);
    acc_at = (i < acc_log.size()) ? acc_log[i] : 32'hDEAD_BEEF;
  endfunction

  function automatic ent_t pop_at(input int i);
    pop_at = (i < pop_log.size()) ? pop_log[i] : {32'hDEAD_BEEF, 32'hDEAD_BEEF};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // memory: returns mem_word(addr) lat cycles after an accepted request
  initial begin
    logic [31:0] a;
    imem_rvalid = 1'b0;
    imem_rdata  = 32'd0;
    forever begin
      @(negedge clk);
      if (rst_n && imem_req && imem_ready) begin
        a = imem_addr;
        repeat (lat) @(posedge clk);
        #1;
        imem_rvalid = 1'b1;
        imem_rdata  = mem_word(a);
        @(posedge clk);
        #1;
        imem_rvalid = 1'b0;
      end
    end
  end

  // compare process and model advance, once per cycle on the falling edge
  always @(negedge clk) begin
    logic exp_req, acc, rv;
    if (!rst_n) begin
      chk("rst_req", imem_req, 0);
      chk("rst_addr", imem_addr, RPC);
      chk("rst_valid", instr_valid, 0);
      chk("rst_instr", instruction, 0);
      chk("rst_pc", instr_pc, 0);
      chk("rst_halted", halted, 0);
      chk("rst_err", fetch_err, 0);
      q.delete();
      m_halt = 0; m_err = 0; m_wait = 0; m_disc = 0; m_started = 0;
      m_addr = RPC; m_rpc = 0;
    end else begin
      exp_req = m_started && !m_halt && !m_wait && (q.size() < 2);
      chk("req", imem_req, exp_req);
      chk("valid", instr_valid, q.size() > 0);
      if (q.size() > 0) begin
        chk("instr", instruction, q[0].ins);
        chk("ipc", instr_pc, q[0].pc);
      end
      if (exp_req) chk("addr", imem_addr, m_addr);
      chk("halted", halted, m_halt);
      chk("ferr", fetch_err, m_err);

      if (imem_req && imem_ready) acc_log.push_back(imem_addr);
      if (instr_valid && instr_ready) pop_log.push_back({instruction, instr_pc});

      acc = exp_req && imem_ready;
      rv  = imem_rvalid;
      if (!m_halt) begin
        if (q.size() > 0 && ill_instr) begin
          m_halt = 1;
          q.delete();
        end else if (redirect) begin
          q.delete();
          if (redirect_pc[1:0] != 2'b00) begin
            m_halt = 1;
            m_err  = 1;
          end else begin
            m_addr = redirect_pc;
            if (m_wait) begin
              if (rv) begin m_wait = 0; m_disc = 0; end
              else m_disc = 1;
            end else if (acc) begin
              m_wait = 1;
              m_disc = 1;
            end
          end
        end else begin
          if (q.size() > 0 && instr_ready) void'(q.pop_front());
          if (m_wait && rv) begin
            if (!m_disc) q.push_back({imem_rdata, m_rpc});
            m_wait = 0;
            m_disc = 0;
          end else if (acc) begin
            m_rpc  = m_addr;
            m_addr = m_addr + 32'd4;
            m_wait = 1;
          end
        end
      end
      m_started = 1;
    end
  end

  task automatic do_reset(input int cycles);
    rst_n = 1'b0;
    repeat (cycles) tick();
    rst_n = 1'b1;
  endtask

  initial begin
    int n;
    ent_t e;
    rst_n       = 1'b0;
    imem_ready  = 1'b1;
    instr_ready = 1'b1;
    redirect    = 1'b0;
    redirect_pc = 32'd0;
    ill_instr   = 1'b0;

    // sequential fetch from RESET_PC
    do_reset(3);
    acc_log.delete(); pop_log.delete();
    repeat (12) tick();
    chk("t1_acc0", acc_at(0), 32'h100);
    chk("t1_acc1", acc_at(1), 32'h104);
    chk("t1_acc2", acc_at(2), 32'h108);
    e = pop_at(0);
    chk("t1_pop0_ins", e.ins, 32'h0050_0093);
    chk("t1_pop0_pc", e.pc, 32'h100);
    e = pop_at(1);
    chk("t1_pop1_pc", e.pc, 32'h104);

    // decode stalled: FIFO fills with two words, fetch stops
    instr_ready = 1'b0;
    do_reset(3);
    repeat (10) tick();
    chk("t2_valid", instr_valid, 1);
    chk("t2_head", instruction, 32'h0050_0093);
    chk("t2_req", imem_req, 0);
    acc_log.delete(); pop_log.delete();
    instr_ready = 1'b1;
    repeat (8) tick();
    e = pop_at(0);
    chk("t2_pop0", e.ins, 32'h0050_0093);
    e = pop_at(1);
    chk("t2_pop1", e.ins, 32'h00A0_0113);
    chk("t2_resume", acc_at(0), 32'h108);

    // redirect while the read of 0x104 is outstanding
    lat = 3;
    do_reset(3);
    n = 0;
    while (!(imem_req && imem_ready && imem_addr == 32'h104) && n < 60) begin
      tick();
      n++;
    end
    chk("t3_wait", n < 60, 1);
    tick();
    redirect = 1'b1; redirect_pc = 32'h200;
    tick();
    redirect = 1'b0;
    acc_log.delete(); pop_log.delete();
    repeat (15) tick();
    chk("t3_acc0", acc_at(0), 32'h200);
    e = pop_at(0);
    chk("t3_pop_pc", e.pc, 32'h200);
    chk("t3_pop_ins", e.ins, mem_word(32'h200));

    // misaligned redirect halts with fetch_err
    redirect = 1'b1; redirect_pc = 32'h202;
    tick();
    redirect = 1'b0;
    chk("t4_halted", halted, 1);
    chk("t4_err", fetch_err, 1);
    acc_log.delete();
    repeat (6) tick();
    chk("t4_no_req", acc_log.size(), 0);

    // illegal head plus same-cycle redirect: halt wins, no fetch_err
    lat = 1;
    instr_ready = 1'b0;
    do_reset(3);
    repeat (6) tick();
    redirect = 1'b1; redirect_pc = 32'h300;
    tick();
    redirect = 1'b0;
    n = 0;
    while (!(instr_valid && instruction == 32'hFFFF_FFFF) && n < 30) begin
      tick();
      n++;
    end
    chk("t5_wait", n < 30, 1);
    ill_instr = 1'b1; redirect = 1'b1; redirect_pc = 32'h400;
    tick();
    ill_instr = 1'b0; redirect = 1'b0;
    chk("t5_halted", halted, 1);
    chk("t5_err", fetch_err, 0);
    chk("t5_valid", instr_valid, 0);
    repeat (4) tick();

    // asynchronous reset while a response is pending
    lat = 3;
    instr_ready = 1'b1;
    do_reset(3);
    n = 0;
    while (!(imem_req && imem_ready) && n < 20) begin
      tick();
      n++;
    end
    chk("t6_wait", n < 20, 1);
    tick();
    #1 rst_n = 1'b0;
    #1;
    chk("t6_req", imem_req, 0);
    chk("t6_addr", imem_addr, RPC);
    chk("t6_valid", instr_valid, 0);
    chk("t6_halted", halted, 0);
    repeat (6) tick();
    lat = 1;
    rst_n = 1'b1;
    acc_log.delete(); pop_log.delete();
    repeat (10) tick();
    e = pop_at(0);
    chk("t6_pop_pc", e.pc, 32'h100);
    chk("t6_pop_ins", e.ins, 32'h0050_0093);

    // fetch PC wraps past the top of the address space
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    tick();
    redirect = 1'b0;
    acc_log.delete(); pop_log.delete();
    repeat (12) tick();
    chk("t7_acc0", acc_at(0), 32'hFFFF_FFFC);
    chk("t7_acc1", acc_at(1), 32'h0000_0000);
    e = pop_at(0);
    chk("t7_pop0_pc", e.pc, 32'hFFFF_FFFC);
    e = pop_at(1);
    chk("t7_pop1_pc", e.pc, 32'h0000_0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
